bus_demux_ctrl: RTL and testbench
=================================

BUS_DEMUX_CTRL -- requirements
Module: bus_demux_ctrl

Interface
REQ-001 SHALL have parameter MEM_WS, default 0, meaning wait states inserted on memory cycles (0..7).
REQ-002 SHALL have parameter IO_WS, default 1, meaning wait states inserted on I/O cycles (0..7).
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports:
  - clock  input  1  sole clock, rising edge.
  - reset_in  input  1  synchronous, active-high reset.
REQ-004 SHALL have CPU-side ports:
  - DATA  inout  8  multiplexed AD[7:0] bus.
  - ADD  input  8  A[15:8].
  - ALE  input  1  address latch enable.
  - S0, S1, IO_Mn  input  1 each  cycle status.
  - RDn, WRn  input  1 each  strobes.
  - READY  output  1  wait request.
REQ-005 SHALL have memory-side ports:
  - mem_addr  output  16  latched address.
  - mem_wdata  output  8  write data.
  - mem_we  output  1  write pulse.
  - mem_re  output  1  read pulse.
  - mem_rdata  input  8  read data, valid one cycle after mem_re.
REQ-006 SHALL have I/O-side ports:
  - io_port  output  8  port number.
  - io_rd, io_wr  output  1 each  strobes.
  - io_rdata  input  8  read data, valid one cycle after io_rd.
REQ-007 SHALL have port cycle_type  output  3  the latched {IO_Mn,S1,S0}.

Function
REQ-008 SHALL sample all CPU inputs on the rising edge of clock only.
REQ-009 SHALL, on any edge with ALE=1 in any state, latch mem_addr={ADD,DATA}, io_port=DATA and cycle_type, and go to LATCHED; any pending strobe is cancelled (abort).
REQ-010 SHALL use FSM states IDLE, LATCHED, RD_WAIT, RD_CAP, RD_HOLD, WR_WAIT, WR_DONE.
REQ-011 SHALL, in LATCHED, go to RD_WAIT on RDn=0, else to WR_WAIT on WRn=0; loading the wait counter with IO_WS if latched IO_Mn=1, else MEM_WS; READY<=0.
REQ-012 SHALL, in RD_WAIT/WR_WAIT, decrement the counter each edge while it is nonzero.
REQ-013 SHALL, at counter=0, pulse the read strobe (mem_re or io_rd, per IO_Mn) for exactly one cycle and enter RD_CAP.
REQ-014 SHALL, in RD_CAP, capture mem_rdata/io_rdata into the read buffer, set READY<=1 and enter RD_HOLD.
REQ-015 SHALL, at counter=0 in WR_WAIT, capture DATA into mem_wdata, pulse mem_we or io_wr for one cycle, set READY<=1 and enter WR_DONE.
REQ-016 SHALL leave RD_HOLD/WR_DONE for IDLE when the respective strobe is sampled high.
REQ-017 SHALL drive DATA with the read buffer only while state=RD_HOLD and RDn=0 (combinational enable); high-Z otherwise.
REQ-018 SHALL hold READY low for exactly WS+2 edges on reads and WS+1 edges on writes, where WS is the applicable wait-state count.
REQ-019 SHALL treat RDn=0 and WRn=0 sampled together in LATCHED as a read.
REQ-020 SHALL ignore strobes in IDLE; a halt status (S1S0=00) latches but issues no strobe if RDn/WRn stay high.
REQ-021 SHALL issue strobes from registered outputs only, never more than one per bus cycle.

Reset
REQ-022 SHALL, on reset_in=1 at a clock edge, set state=IDLE, READY=1, mem_addr=0, mem_wdata=0, io_port=0, cycle_type=0, all strobes=0, read buffer=0, counter=0 and DATA high-Z.
REQ-023 SHALL abort any mid-cycle operation at reset with no strobe issued; reset overrides ALE.

Configuration
REQ-024 SHALL, when macro BUS_DEMUX_CTRL_ERR_EN is defined, add output bus_err (1 bit, reset 0), set sticky on any edge with RDn=0 and WRn=0, or with a strobe low in IDLE, cleared only by reset.
REQ-025 SHALL, when BUS_DEMUX_CTRL_ERR_EN is undefined, have no bus_err port and no detection logic.

Structure
REQ-026 SHALL place the FSM state enum, cycle-status encodings (mem read 010, mem write 001, fetch 011, io read 110, io write 101) and WS width constant in package bus_demux_pkg.
REQ-027 SHALL implement the wait counter as sub-module bus_ws_counter (load, decrement, zero flag).

Verification
REQ-028 Memory read, MEM_WS=0: ALE with ADD=0x01, DATA=0x00, then RDn=0, mem_rdata=0x3E -> mem_addr=0x0100, one mem_re pulse, READY low 2 cycles, DATA=0x3E until RDn rises.
REQ-029 Memory write, MEM_WS=2: address 0x20FF, WRn=0 with DATA=0xA5 -> READY low 3 cycles, single mem_we with mem_wdata=0xA5, mem_addr=0x20FF.
REQ-030 I/O read, IO_WS=1: IO_Mn=1, port 0x42, io_rdata=0x7C -> io_rd once, io_port=0x42, READY low 3 cycles, no mem_re.
REQ-031 Abort: ALE re-asserted during RD_WAIT with new address 0x3000 -> no strobe for the old cycle; new cycle proceeds with mem_addr=0x3000.
REQ-032 Reset in RD_WAIT -> next edge READY=1, no strobes, DATA high-Z, state IDLE.
REQ-033 With BUS_DEMUX_CTRL_ERR_EN: RDn=0 and WRn=0 together -> read performed, bus_err=1 held until reset.

Source files
------------

// File: rtl/bus_demux_pkg.sv
// Shared definitions for the multiplexed-bus demultiplexer controller:
// FSM state encoding, CPU cycle-status codes and the wait-counter width.
package bus_demux_pkg;

  // Wait-state counter width (supports 0..7 wait states)
  localparam int WS_W = 3;

  // Controller state encoding
  typedef enum logic [2:0] {
    IDLE,
    LATCHED,
    RD_WAIT,
    RD_CAP,
    RD_HOLD,
    WR_WAIT,
    WR_DONE
  } state_t;

  // Cycle status encodings as {IO_Mn, S1, S0}
  localparam logic [2:0] CT_HALT   = 3'b000;
  localparam logic [2:0] CT_MEM_WR = 3'b001;
  localparam logic [2:0] CT_MEM_RD = 3'b010;
  localparam logic [2:0] CT_FETCH  = 3'b011;
  localparam logic [2:0] CT_IO_WR  = 3'b101;
  localparam logic [2:0] CT_IO_RD  = 3'b110;

  // True when the latched cycle status selects the I/O space
  function automatic logic is_io(input logic [2:0] ct);
    return ct[2];
  endfunction

endpackage

// File: rtl/bus_ws_counter.sv
// Wait-state down-counter: loads a wait-state count, decrements it one
// step per request while nonzero and flags when it has reached zero.
module bus_ws_counter
  import bus_demux_pkg::*;
(
  input  logic            clock,
  input  logic            reset_in,
  input  logic            load,
  input  logic [WS_W-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [WS_W-1:0] count_reg;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clock) begin
    if (reset_in) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WS_W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/bus_demux_ctrl.sv
// Multiplexed AD-bus demultiplexer: latches the address on ALE, inserts
// programmable wait states and converts RDn/WRn into single-cycle memory
// or I/O strobes. Optional sticky protocol-error flag via macro
// BUS_DEMUX_CTRL_ERR_EN (adds the bus_err output when defined).
module bus_demux_ctrl
  import bus_demux_pkg::*;
#(
  parameter int MEM_WS = 0,
  parameter int IO_WS  = 1
) (
  input  logic        clock,
  input  logic        reset_in,
  inout  wire  [7:0]  DATA,
  input  logic [7:0]  ADD,
  input  logic        ALE,
  input  logic        S0,
  input  logic        S1,
  input  logic        IO_Mn,
  input  logic        RDn,
  input  logic        WRn,
  output logic        READY,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_port,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [7:0]  io_rdata,
  output logic [2:0]  cycle_type
`ifdef BUS_DEMUX_CTRL_ERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam logic [WS_W-1:0] MEM_WS_V = WS_W'(MEM_WS);
  localparam logic [WS_W-1:0] IO_WS_V  = WS_W'(IO_WS);

  state_t          state_reg;
  logic [7:0]      rbuf_reg;
  logic            ws_load;
  logic            ws_dec;
  logic            ws_zero;
  logic [WS_W-1:0] ws_load_val;
  logic            data_oe;

  // Wait counter control: load when a strobe starts the access, count down in the wait states
  always_comb begin
    ws_load     = (state_reg == LATCHED) && !ALE && (!RDn || !WRn);
    ws_dec      = ((state_reg == RD_WAIT) || (state_reg == WR_WAIT)) && !ALE;
    ws_load_val = is_io(cycle_type) ? IO_WS_V : MEM_WS_V;
  end

  bus_ws_counter u_ws_counter (
    .clock    (clock),
    .reset_in (reset_in),
    .load     (ws_load),
    .load_val (ws_load_val),
    .dec      (ws_dec),
    .zero     (ws_zero)
  );

  // Read data goes back onto the AD bus only while the CPU is still reading
  assign data_oe = (state_reg == RD_HOLD) && !RDn;
  assign DATA    = data_oe ? rbuf_reg : 8'hzz;

  // Bus-cycle FSM with registered strobes, READY and latched address/status
  always_ff @(posedge clock) begin
    if (reset_in) begin
      state_reg  <= IDLE;
      READY      <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      io_port    <= '0;
      cycle_type <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      io_rd      <= 1'b0;
      io_wr      <= 1'b0;
      rbuf_reg   <= '0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      io_rd  <= 1'b0;
      io_wr  <= 1'b0;
      if (ALE) begin
        // A new address phase aborts whatever cycle was in progress
        mem_addr   <= {ADD, DATA};
        io_port    <= DATA;
        cycle_type <= {IO_Mn, S1, S0};
        READY      <= 1'b1;
        state_reg  <= LATCHED;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= IDLE;
          end
          LATCHED: begin
            // Read wins when both strobes are seen together
            if (!RDn) begin
              READY     <= 1'b0;
              state_reg <= RD_WAIT;
            end else if (!WRn) begin
              READY     <= 1'b0;
              state_reg <= WR_WAIT;
            end
          end
          RD_WAIT: begin
            if (ws_zero) begin
              if (is_io(cycle_type)) begin
                io_rd <= 1'b1;
              end else begin
                mem_re <= 1'b1;
              end
              state_reg <= RD_CAP;
            end
          end
          RD_CAP: begin
            rbuf_reg  <= is_io(cycle_type) ? io_rdata : mem_rdata;
            READY     <= 1'b1;
            state_reg <= RD_HOLD;
          end
          RD_HOLD: begin
            if (RDn) begin
              state_reg <= IDLE;
            end
          end
          WR_WAIT: begin
            if (ws_zero) begin
              mem_wdata <= DATA;
              if (is_io(cycle_type)) begin
                io_wr <= 1'b1;
              end else begin
                mem_we <= 1'b1;
              end
              READY     <= 1'b1;
              state_reg <= WR_DONE;
            end
          end
          WR_DONE: begin
            if (WRn) begin
              state_reg <= IDLE;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef BUS_DEMUX_CTRL_ERR_EN
  // Sticky protocol error: both strobes low, or a strobe outside any bus cycle
  always_ff @(posedge clock) begin
    if (reset_in) begin
      bus_err <= 1'b0;
    end else if ((!RDn && !WRn) || ((state_reg == IDLE) && (!RDn || !WRn))) begin
      bus_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_demux_ctrl.sv
// Self-checking bench for bus_demux_ctrl: directed scenarios with literal
// expectations plus randomized bus cycles checked every cycle against a
// timeline-based reference model.
module tb_bus_demux_ctrl;

  localparam int A_MEM_WS = 0;
  localparam int A_IO_WS  = 1;
  localparam int B_MEM_WS = 2;
  localparam int B_IO_WS  = 1;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       ale = 1'b0;
  logic [7:0] add = 8'h00;
  logic       s0 = 1'b0;
  logic       s1 = 1'b0;
  logic       io_mn = 1'b0;
  logic       rdn = 1'b1;
  logic       wrn = 1'b1;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] io_rdata = 8'h00;
  logic       tb_en = 1'b1;
  logic [7:0] tb_val = 8'h00;

  wire  [7:0] data_a;
  wire  [7:0] data_b;
  assign data_a = tb_en ? tb_val : 8'hzz;
  assign data_b = tb_en ? tb_val : 8'hzz;

  logic        ready_a, mem_we_a, mem_re_a, io_rd_a, io_wr_a;
  logic [15:0] mem_addr_a;
  logic [7:0]  mem_wdata_a, io_port_a;
  logic [2:0]  cycle_type_a;
  logic        ready_b, mem_we_b, mem_re_b, io_rd_b, io_wr_b;
  logic [15:0] mem_addr_b;
  logic [7:0]  mem_wdata_b, io_port_b;
  logic [2:0]  cycle_type_b;
`ifdef BUS_DEMUX_CTRL_ERR_EN
  logic        bus_err_a, bus_err_b;
`endif

  bus_demux_ctrl #(.MEM_WS(A_MEM_WS), .IO_WS(A_IO_WS)) dut_a (
    .clock(clock), .reset_in(rst), .DATA(data_a), .ADD(add), .ALE(ale),
    .S0(s0), .S1(s1), .IO_Mn(io_mn), .RDn(rdn), .WRn(wrn), .READY(ready_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
    .mem_re(mem_re_a), .mem_rdata(mem_rdata), .io_port(io_port_a),
    .io_rd(io_rd_a), .io_wr(io_wr_a), .io_rdata(io_rdata),
    .cycle_type(cycle_type_a)
`ifdef BUS_DEMUX_CTRL_ERR_EN
    , .bus_err(bus_err_a)
`endif
  );

  bus_demux_ctrl #(.MEM_WS(B_MEM_WS), .IO_WS(B_IO_WS)) dut_b (
    .clock(clock), .reset_in(rst), .DATA(data_b), .ADD(add), .ALE(ale),
    .S0(s0), .S1(s1), .IO_Mn(io_mn), .RDn(rdn), .WRn(wrn), .READY(ready_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .mem_re(mem_re_b), .mem_rdata(mem_rdata), .io_port(io_port_b),
    .io_rd(io_rd_b), .io_wr(io_wr_b), .io_rdata(io_rdata),
    .cycle_type(cycle_type_b)
`ifdef BUS_DEMUX_CTRL_ERR_EN
    , .bus_err(bus_err_b)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // ---------------- reference model for dut_a ----------------
  // A bus cycle is described by its start edge m_t0 (strobe first seen in
  // the latched phase) and its wait-state count; every output follows from
  // the edge distance k = edge_n - m_t0.
  int          edge_n = 0;
  int          m_t0 = 0;
  int          m_len = 0;
  int          m_ws = 0;
  logic        m_lat = 1'b0;
  logic        m_act = 1'b0;
  logic        m_rd = 1'b0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_port = '0;
  logic [2:0]  m_ct = '0;
  logic [7:0]  m_wdata = '0;
  logic        m_wd_known = 1'b1;
  logic [7:0]  m_rbuf = '0;
  logic        m_err = 1'b0;

  task automatic model_step();
    logic idle_pre;
    int   k;
    idle_pre = !m_lat && !m_act;
    edge_n++;
    if (rst) begin
      m_lat = 0; m_act = 0; m_addr = '0; m_port = '0; m_ct = '0;
      m_wdata = '0; m_wd_known = 1; m_rbuf = '0; m_err = 0;
      return;
    end
    if (!rdn && !wrn) m_err = 1;
    if (idle_pre && (!rdn || !wrn)) m_err = 1;
    if (ale) begin
      m_addr = {add, tb_val};
      m_port = tb_val;
      m_ct   = {io_mn, s1, s0};
      m_lat  = 1;
      m_act  = 0;
      return;
    end
    if (m_lat) begin
      if (!rdn || !wrn) begin
        m_lat = 0;
        m_act = 1;
        m_rd  = !rdn;
        m_ws  = m_ct[2] ? A_IO_WS : A_MEM_WS;
        m_len = m_rd ? m_ws + 2 : m_ws + 1;
        m_t0  = edge_n;
      end
      return;
    end
    if (m_act) begin
      k = edge_n - m_t0;
      if (!m_rd && k == m_len) begin
        m_wdata = tb_val;
        m_wd_known = tb_en;
      end
      if (m_rd && k == m_len) m_rbuf = m_ct[2] ? io_rdata : mem_rdata;
      if (k > m_len && (m_rd ? rdn : wrn)) m_act = 0;
    end
  endtask

  always @(posedge clock) model_step();

  // ---------------- per-cycle compare process ----------------
  int   ck;
  logic e_rs, e_ws, e_rdy, e_drv;
  always @(negedge clock) begin
    if (chk_en) begin
      ck    = edge_n - m_t0;
      e_rs  = m_act && m_rd && (ck == m_len - 1);
      e_ws  = m_act && !m_rd && (ck == m_len);
      e_rdy = !(m_act && ck < m_len);
      e_drv = m_act && m_rd && (ck >= m_len) && !rdn;
      cmp("ready", {15'd0, ready_a}, {15'd0, e_rdy});
      cmp("mem_re", {15'd0, mem_re_a}, {15'd0, e_rs && !m_ct[2]});
      cmp("io_rd", {15'd0, io_rd_a}, {15'd0, e_rs && m_ct[2]});
      cmp("mem_we", {15'd0, mem_we_a}, {15'd0, e_ws && !m_ct[2]});
      cmp("io_wr", {15'd0, io_wr_a}, {15'd0, e_ws && m_ct[2]});
      cmp("mem_addr", mem_addr_a, m_addr);
      cmp("io_port", {8'd0, io_port_a}, {8'd0, m_port});
      cmp("cycle_type", {13'd0, cycle_type_a}, {13'd0, m_ct});
      if (m_wd_known) cmp("mem_wdata", {8'd0, mem_wdata_a}, {8'd0, m_wdata});
      if (e_drv) cmp("data_drive", {8'd0, data_a}, {8'd0, m_rbuf});
      else if (tb_en) cmp("data_hiz", {8'd0, data_a}, {8'd0, tb_val});
`ifdef BUS_DEMUX_CTRL_ERR_EN
      cmp("bus_err", {15'd0, bus_err_a}, {15'd0, m_err});
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rtick();
    mem_rdata = 8'($urandom);
    io_rdata  = 8'($urandom);
    tick();
  endtask

  task automatic ale_cycle(input logic [15:0] a, input logic io, input logic st1, input logic st0);
    ale = 1; add = a[15:8]; tb_val = a[7:0]; tb_en = 1; rdn = 1; wrn = 1;
    io_mn = io; s1 = st1; s0 = st0;
    tick();
    ale = 0;
  endtask

  task automatic release_bus();
    rdn = 1; wrn = 1; tb_en = 1; tb_val = 8'h00;
    tick();
    tick();
  endtask

  int lo, re, we, iord, strb, hold, gap, op, rpt;
  logic [7:0]  wcap;
  logic [15:0] ra;

  initial begin
    // reset state
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk_en = 1;
    @(negedge clock);
    cmp("rst_ready", {15'd0, ready_a}, 16'd1);
    cmp("rst_addr", mem_addr_a, 16'h0000);
    cmp("rst_ct", {13'd0, cycle_type_a}, 16'd0);
    cmp("rst_strobes", {12'd0, mem_re_a, mem_we_a, io_rd_a, io_wr_a}, 16'd0);

    // memory read, no wait states
    ale_cycle(16'h0100, 1'b0, 1'b1, 1'b0);
    mem_rdata = 8'h3E; rdn = 0; tb_en = 0;
    lo = 0; re = 0;
    repeat (6) begin
      tick();
      @(negedge clock);
      if (!ready_a) lo++;
      if (mem_re_a) re++;
    end
    cmp("rd_ready_low", 16'(lo), 16'd2);
    cmp("rd_mem_re_cnt", 16'(re), 16'd1);
    cmp("rd_data", {8'd0, data_a}, 16'h003E);
    cmp("rd_addr", mem_addr_a, 16'h0100);
    cmp("model_rbuf", {8'd0, m_rbuf}, 16'h003E);
    release_bus();

    // memory write, two wait states (dut_b)
    ale_cycle(16'h20FF, 1'b0, 1'b0, 1'b1);
    wrn = 0; tb_val = 8'hA5;
    lo = 0; we = 0; wcap = 8'h00;
    repeat (8) begin
      tick();
      @(negedge clock);
      if (!ready_b) lo++;
      if (mem_we_b) begin we++; wcap = mem_wdata_b; end
    end
    cmp("wr_ready_low", 16'(lo), 16'd3);
    cmp("wr_mem_we_cnt", 16'(we), 16'd1);
    cmp("wr_wdata", {8'd0, wcap}, 16'h00A5);
    cmp("wr_addr", mem_addr_b, 16'h20FF);
    release_bus();

    // I/O read, one wait state
    ale_cycle(16'h0042, 1'b1, 1'b1, 1'b0);
    io_rdata = 8'h7C; rdn = 0; tb_en = 0;
    lo = 0; iord = 0; re = 0;
    repeat (8) begin
      tick();
      @(negedge clock);
      if (!ready_a) lo++;
      if (io_rd_a) iord++;
      if (mem_re_a) re++;
    end
    cmp("io_ready_low", 16'(lo), 16'd3);
    cmp("io_rd_cnt", 16'(iord), 16'd1);
    cmp("io_no_mem_re", 16'(re), 16'd0);
    cmp("io_port", {8'd0, io_port_a}, 16'h0042);
    cmp("io_data", {8'd0, data_a}, 16'h007C);
    release_bus();

    // abort by ALE while waiting
    ale_cycle(16'h1234, 1'b0, 1'b1, 1'b0);
    rdn = 0; tb_en = 0; strb = 0;
    tick();
    @(negedge clock);
    strb += int'(mem_re_a) + int'(mem_re_b);
    ale = 1; add = 8'h30; tb_val = 8'h00; tb_en = 1; rdn = 1;
    tick();
    @(negedge clock);
    strb += int'(mem_re_a) + int'(mem_re_b);
    ale = 0; rdn = 0; tb_en = 0; mem_rdata = 8'h11;
    re = 0; we = 0;
    repeat (8) begin
      tick();
      @(negedge clock);
      if (mem_re_a) re++;
      if (mem_re_b) we++;
    end
    cmp("abort_no_strobe", 16'(strb), 16'd0);
    cmp("abort_new_re_a", 16'(re), 16'd1);
    cmp("abort_new_re_b", 16'(we), 16'd1);
    cmp("abort_addr_a", mem_addr_a, 16'h3000);
    cmp("abort_addr_b", mem_addr_b, 16'h3000);
    release_bus();

    // reset during a read wait
    ale_cycle(16'h5501, 1'b0, 1'b1, 1'b0);
    rdn = 0; tb_en = 0;
    tick();
    tick();
    rst = 1; tb_en = 1; tb_val = 8'h5A;
    tick();
    @(negedge clock);
    cmp("rstw_ready", {15'd0, ready_b}, 16'd1);
    cmp("rstw_strobes", {12'd0, mem_re_b, mem_we_b, io_rd_b, io_wr_b}, 16'd0);
    cmp("rstw_addr", mem_addr_b, 16'h0000);
    cmp("rstw_hiz", {8'd0, data_b}, 16'h005A);
    rst = 0;
    strb = 0;
    repeat (3) begin
      tick();
      @(negedge clock);
      strb += int'(mem_re_b) + int'(io_rd_b) + int'(!ready_b);
    end
    cmp("rstw_idle_quiet", 16'(strb), 16'd0);
    release_bus();

`ifdef BUS_DEMUX_CTRL_ERR_EN
    // both strobes low: read wins, error flag sticks until reset
    rst = 1;
    tick();
    rst = 0;
    @(negedge clock);
    cmp("err_clear", {15'd0, bus_err_a}, 16'd0);
    ale_cycle(16'h0800, 1'b0, 1'b1, 1'b0);
    rdn = 0; wrn = 0; tb_en = 0;
    re = 0; we = 0;
    repeat (6) begin
      tick();
      @(negedge clock);
      if (mem_re_a) re++;
      if (mem_we_a) we++;
    end
    release_bus();
    @(negedge clock);
    cmp("err_read_done", 16'(re), 16'd1);
    cmp("err_no_write", 16'(we), 16'd0);
    cmp("err_sticky", {15'd0, bus_err_a}, 16'd1);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clock);
    cmp("err_reset", {15'd0, bus_err_a}, 16'd0);
`endif

    // randomized bus cycles
    for (int t = 0; t < 1200; t++) begin
      ra = 16'($urandom);
      ale = 1; add = ra[15:8]; tb_val = ra[7:0]; tb_en = 1; rdn = 1; wrn = 1;
      io_mn = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      s0 = 1'($urandom_range(0, 1));
      rtick();
      ale = 0;
      repeat ($urandom_range(0, 2)) rtick();
      op   = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 12));
      rpt  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 11)) : -1;
      for (int i = 0; i < hold; i++) begin
        rdn = !(op <= 3 || op == 8);
        wrn = !(op >= 4 && op <= 8);
        tb_en = rdn;
        if (tb_en) tb_val = 8'($urandom);
        rst = (i == rpt);
        rtick();
      end
      rst = 0;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        rdn = ($urandom_range(0, 5) != 0);
        wrn = 1;
        tb_en = rdn;
        tb_val = 8'($urandom);
        rtick();
      end
      rdn = 1; wrn = 1; tb_en = 1;
    end

    release_bus();
    @(negedge clock);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
